// File: rtl/cnn_mac_pipe_if.sv
// Operand/result bus of the conv1 MAC engine.
// The master drives operand beats and the slave returns rounded results.
interface cnn_mac_pipe_if #(
  parameter int A_WIDTH   = 10,
  parameter int B_WIDTH   = 14,
  parameter int OUT_WIDTH = 16
);
  logic                        in_valid;
  logic signed [A_WIDTH-1:0]   in_a;
  logic signed [B_WIDTH-1:0]   in_b;
  logic                        in_first;
  logic                        in_last;
  logic                        out_valid;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_first, in_last,
    input  out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last,
    output out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/cnn_mac_pipe.sv
// Pipelined signed multiply-accumulate for conv1: a product pipeline of
// MUL_STAGES registers, a framed accumulator, then round/shift/saturate
// into a one-cycle result strobe. ce=0 freezes every register.
module cnn_mac_pipe #(
  parameter int A_WIDTH    = 10,
  parameter int B_WIDTH    = 14,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int MUL_STAGES = 2
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  input  logic           ce,
  cnn_mac_pipe_if.slave  bus
);

  localparam int PW      = A_WIDTH + B_WIDTH;
  localparam int LAST    = MUL_STAGES - 1;
  localparam int RND_POS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

  // Half-LSB rounding constant; zero when no fractional bits are dropped.
  localparam logic [ACC_WIDTH:0] RND =
    (FRAC_SHIFT > 0) ? ({{ACC_WIDTH{1'b0}}, 1'b1} << RND_POS) : '0;

  localparam logic signed [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [ACC_WIDTH:0]   LIM_MAX = (ACC_WIDTH+1)'(SAT_MAX);
  localparam logic signed [ACC_WIDTH:0]   LIM_MIN = (ACC_WIDTH+1)'(SAT_MIN);

  logic signed [PW-1:0]        prod_q [MUL_STAGES];
  logic signed [PW-1:0]        prod_d [MUL_STAGES];
  logic [MUL_STAGES-1:0]       vld_q, vld_d;
  logic [MUL_STAGES-1:0]       fst_q, fst_d;
  logic [MUL_STAGES-1:0]       lst_q, lst_d;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        acc_lst_q, acc_lst_d;
  logic signed [ACC_WIDTH-1:0] prod_ext;

  logic signed [ACC_WIDTH:0]   rnd_sum;
  logic signed [ACC_WIDTH:0]   shifted;
  logic signed [OUT_WIDTH-1:0] sat_val;
  logic                        sat_hit;

  logic                        out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                        out_ovf_q, out_ovf_d;

  // Product pipeline next state: multiply at stage 0, shift flags and products along.
  always_comb begin
    prod_d = prod_q;
    vld_d  = vld_q;
    fst_d  = fst_q;
    lst_d  = lst_q;
    if (ce) begin
      prod_d[0] = PW'(bus.in_a) * PW'(bus.in_b);
      vld_d[0]  = bus.in_valid;
      fst_d[0]  = bus.in_valid & bus.in_first;
      lst_d[0]  = bus.in_valid & bus.in_last;
      for (int i = 1; i < MUL_STAGES; i++) begin
        prod_d[i] = prod_q[i-1];
        vld_d[i]  = vld_q[i-1];
        fst_d[i]  = fst_q[i-1];
        lst_d[i]  = lst_q[i-1];
      end
    end
  end

  // Product pipeline registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      prod_q <= '{default: '0};
      vld_q  <= '0;
      fst_q  <= '0;
      lst_q  <= '0;
    end else begin
      prod_q <= prod_d;
      vld_q  <= vld_d;
      fst_q  <= fst_d;
      lst_q  <= lst_d;
    end
  end

  // Accumulate: a first beat restarts the sum, others wrap-add; remember whether it closed a frame.
  always_comb begin
    prod_ext  = ACC_WIDTH'(prod_q[LAST]);
    acc_d     = acc_q;
    acc_lst_d = acc_lst_q;
    if (ce) begin
      acc_lst_d = 1'b0;
      if (vld_q[LAST]) begin
        acc_d     = fst_q[LAST] ? prod_ext : acc_q + prod_ext;
        acc_lst_d = lst_q[LAST];
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q     <= '0;
      acc_lst_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_lst_q <= acc_lst_d;
    end
  end

  // Round half-up, arithmetic shift, clamp to the output range; one extra bit keeps the rounding add exact.
  always_comb begin
    rnd_sum = {acc_q[ACC_WIDTH-1], acc_q} + RND;
    shifted = rnd_sum >>> FRAC_SHIFT;
    sat_hit = 1'b0;
    sat_val = shifted[OUT_WIDTH-1:0];
    if (shifted > LIM_MAX) begin
      sat_val = SAT_MAX;
      sat_hit = 1'b1;
    end else if (shifted < LIM_MIN) begin
      sat_val = SAT_MIN;
      sat_hit = 1'b1;
    end
  end

  // Result strobe; data and overflow flag only change when a frame completes.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (ce) begin
      out_valid_d = acc_lst_q;
      if (acc_lst_q) begin
        out_data_d = sat_val;
        out_ovf_d  = sat_hit;
      end
    end
  end

  // Output registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Directed bench for cnn_mac_pipe with default parameters.
module tb_cnn_mac_pipe;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  logic ce       = 1'b0;

  cnn_mac_pipe_if #(.A_WIDTH(10), .B_WIDTH(14), .OUT_WIDTH(16)) bus ();

  cnn_mac_pipe dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ce       (ce),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int n;
    int a[3];
    int b[3];
    int exp_d;
    int exp_o;
  } vec_t;

  typedef struct {
    logic c;
    logic v;
    int   a;
    int   b;
    logic f;
    logic l;
    int   exp_v;
    int   exp_d;
  } stall_t;

  vec_t   vecs[7];
  stall_t stl[16];

  int   total = 0;
  int   bad   = 0;
  logic obs_v;
  logic obs_o;
  int   obs_d;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs mid-cycle, advance past the edge.
  task automatic cyc(input logic c, input logic v, input int a, input int b,
                     input logic f, input logic l);
    ce           = c;
    bus.in_valid = v;
    bus.in_a     = 10'(a);
    bus.in_b     = 14'(b);
    bus.in_first = f;
    bus.in_last  = l;
    @(negedge ap_clk);
    obs_v = bus.out_valid;
    obs_d = int'(bus.out_data);
    obs_o = bus.out_ovf;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    lat = 0;
    for (int i = 0; i < v.n; i++)
      cyc(1'b1, 1'b1, v.a[i], v.b[i], i == 0, i == v.n - 1);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      if (obs_v) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_latency"}, lat, 4);
      check({tag, "_data"}, obs_d, v.exp_d);
      check({tag, "_ovf"}, int'(obs_o), v.exp_o);
      cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      check({tag, "_strobe_end"}, int'(obs_v), 0);
      check({tag, "_data_hold"}, obs_d, v.exp_d);
    end
  endtask

  initial begin
    int cnt;
    int last_d;

    vecs[0] = '{n: 3, a: '{100, -50, 7},     b: '{200, 300, -8},       exp_d: 19,     exp_o: 0};
    vecs[1] = '{n: 1, a: '{1, 0, 0},         b: '{128, 0, 0},          exp_d: 1,      exp_o: 0};
    vecs[2] = '{n: 1, a: '{-1, 0, 0},        b: '{1, 0, 0},            exp_d: 0,      exp_o: 0};
    vecs[3] = '{n: 1, a: '{2, 0, 0},         b: '{-128, 0, 0},         exp_d: -1,     exp_o: 0};
    vecs[4] = '{n: 1, a: '{-1, 0, 0},        b: '{128, 0, 0},          exp_d: 0,      exp_o: 0};
    vecs[5] = '{n: 3, a: '{511, 511, 511},   b: '{8191, 8191, 8191},   exp_d: 32767,  exp_o: 1};
    vecs[6] = '{n: 3, a: '{-512, -512, -512}, b: '{8191, 8191, 8191},  exp_d: -32768, exp_o: 1};

    // Dot1 (19) and single-term dot2 (1) with a bubble, then ce=0 over cycles 7..9 while dot1's strobe is up.
    for (int j = 0; j < 16; j++) stl[j] = '{c: 1'b1, v: 1'b0, a: 0, b: 0, f: 1'b0, l: 1'b0, exp_v: 0, exp_d: 0};
    stl[0] = '{c: 1'b1, v: 1'b1, a: 100, b: 200,  f: 1'b1, l: 1'b0, exp_v: 0, exp_d: 0};
    stl[2] = '{c: 1'b1, v: 1'b1, a: -50, b: 300,  f: 1'b0, l: 1'b0, exp_v: 0, exp_d: 0};
    stl[3] = '{c: 1'b1, v: 1'b1, a: 7,   b: -8,   f: 1'b0, l: 1'b1, exp_v: 0, exp_d: 0};
    stl[4] = '{c: 1'b1, v: 1'b1, a: 1,   b: 128,  f: 1'b1, l: 1'b1, exp_v: 0, exp_d: 0};
    stl[7] = '{c: 1'b0, v: 1'b1, a: 511, b: 8191, f: 1'b1, l: 1'b1, exp_v: 1, exp_d: 19};
    stl[8] = '{c: 1'b0, v: 1'b1, a: 511, b: 8191, f: 1'b1, l: 1'b1, exp_v: 1, exp_d: 19};
    stl[9] = '{c: 1'b0, v: 1'b1, a: -512, b: 8191, f: 1'b1, l: 1'b1, exp_v: 1, exp_d: 19};
    stl[10].exp_v = 1; stl[10].exp_d = 19;
    stl[11].exp_v = 1; stl[11].exp_d = 1;

    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;

    // Reset state.
    @(negedge ap_clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_ovf", int'(bus.out_ovf), 0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    // Table vectors.
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    end

    // Asynchronous reset with two beats in flight.
    cyc(1'b1, 1'b1, 511, 8191, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 511, 8191, 1'b0, 1'b1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(bus.out_valid), 0);
    check("arst_out_data", int'(bus.out_data), 0);
    check("arst_out_ovf", int'(bus.out_ovf), 0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      if (obs_v) cnt++;
    end
    check("arst_no_spurious", cnt, 0);
    run_vec(vecs[0], "post_rst");
    cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    // Bubbles, back-to-back frames and a 3-cycle stall.
    for (int j = 0; j < 16; j++) begin
      cyc(stl[j].c, stl[j].v, stl[j].a, stl[j].b, stl[j].f, stl[j].l);
      check($sformatf("stall_valid_c%0d", j), int'(obs_v), stl[j].exp_v);
      if (stl[j].exp_v != 0) begin
        check($sformatf("stall_data_c%0d", j), obs_d, stl[j].exp_d);
        check($sformatf("stall_ovf_c%0d", j), int'(obs_o), 0);
      end
    end

    // First re-issued before last: only the restarted sum 2*128+3*128 -> 3.
    cyc(1'b1, 1'b1, 100, 200, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, -50, 300, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2, 128, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 3, 128, 1'b0, 1'b1);
    cnt    = 0;
    last_d = -99999;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      if (obs_v) begin
        cnt++;
        last_d = obs_d;
      end
    end
    check("restart_strobes", cnt, 1);
    check("restart_data", last_d, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
